// File: rtl/baseline_pkg.sv
// Shared types and helpers for the multi-channel baseline tracker.
package baseline_pkg;

  typedef enum logic [1:0] {
    S_WAIT,
    S_ACC,
    S_CLOSE,
    S_IDLE
  } state_t;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned log2n);
    return dw + log2n;
  endfunction

endpackage

// File: rtl/baseline_tracker_if.sv
// Sample input / baseline output bundle between ADC capture and the baseline tracker.
interface baseline_tracker_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned DW  = 14
);

  logic [NCH*DW-1:0] indata;
  logic              in_valid;
  logic              start;
  logic [NCH*DW-1:0] baseline;
  logic              done;
  logic              upd;
  logic [NCH-1:0]    timeout_err;

  modport master (
    output indata, in_valid, start,
    input  baseline, done, upd, timeout_err
  );

  modport slave (
    input  indata, in_valid, start,
    output baseline, done, upd, timeout_err
  );

endinterface

// File: rtl/baseline_chan.sv
// One channel: windowed accumulator with pulse rejection, valid flag and baseline register.
module baseline_chan
  import baseline_pkg::*;
#(
  parameter int unsigned DW     = 14,
  parameter int unsigned LOG2N  = 7,
  parameter int unsigned THRESH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          close,
  input  logic          sample_en,
  input  logic [DW-1:0] sample,
  output logic          full,
  output logic          full_next,
  output logic          valid,
  output logic [DW-1:0] baseline
);

  localparam int unsigned AW = acc_width(DW, LOG2N);
  localparam int unsigned CW = LOG2N + 1;
  localparam logic [CW-1:0] WIN    = {1'b1, {LOG2N{1'b0}}};
  localparam logic [CW-1:0] WIN_M1 = {1'b0, {LOG2N{1'b1}}};
  localparam logic [DW-1:0] THR    = DW'(THRESH);

  logic [AW-1:0] acc;
  logic [CW-1:0] count;
  logic [DW-1:0] diff;
  logic          accept;
  logic          take;

  always_comb begin
    diff   = (sample >= baseline) ? (sample - baseline) : (baseline - sample);
    accept = (THRESH == 0) || !valid || (diff <= THR);
    take   = sample_en && !full && accept;
  end

  assign full = (count == WIN);
  // Lookahead lets the FSM leave ACC on the same edge the last sample lands.
  assign full_next = full || (take && (count == WIN_M1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      valid    <= 1'b0;
      baseline <= '0;
    end else begin
      if (close && full) begin
        baseline <= acc[AW-1 -: DW];
        valid    <= 1'b1;
      end
      if (clear) begin
        acc   <= '0;
        count <= '0;
      end else if (take) begin
        acc   <= acc + AW'(sample);
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/baseline_tracker.sv
// Multi-channel periodic baseline tracker: settling wait, windowed averaging, timeout flags.
module baseline_tracker
  import baseline_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned DW       = 14,
  parameter int unsigned LOG2N    = 7,
  parameter int unsigned INITWAIT = 1000000,
  parameter int unsigned PERIOD   = 0,
  parameter int unsigned THRESH   = 0,
  parameter int unsigned MAXCYC   = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  baseline_tracker_if.slave  bus
);

  localparam int unsigned WAIT_LAST = (INITWAIT > 0) ? INITWAIT - 1 : 0;
  localparam int unsigned ACC_LAST  = (MAXCYC > 0) ? MAXCYC - 1 : 0;

  state_t            state;
  logic [31:0]       cnt;
  logic              upd_q;
  logic              done_q;
  logic [NCH-1:0]    terr_q;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    full_next;
  logic [NCH-1:0]    valid;
  logic [NCH*DW-1:0] base_w;
  logic              acc_en;
  logic              in_close;

  assign acc_en   = (state == S_ACC) && bus.in_valid;
  assign in_close = (state == S_CLOSE);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    baseline_chan #(
      .DW     (DW),
      .LOG2N  (LOG2N),
      .THRESH (THRESH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (in_close),
      .close     (in_close),
      .sample_en (acc_en),
      .sample    (bus.indata[c*DW +: DW]),
      .full      (full[c]),
      .full_next (full_next[c]),
      .valid     (valid[c]),
      .baseline  (base_w[c*DW +: DW])
    );
  end

  // One counter serves WAIT, ACC and IDLE; it is zeroed on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_WAIT;
      cnt    <= '0;
      upd_q  <= 1'b0;
      done_q <= 1'b0;
      terr_q <= '0;
    end else begin
      upd_q <= 1'b0;
      case (state)
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= S_ACC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_ACC: begin
          if ((&full_next) || (cnt == ACC_LAST)) begin
            state <= S_CLOSE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_CLOSE: begin
          upd_q  <= 1'b1;
          terr_q <= ~full;
          done_q <= done_q | (&(valid | full));
          state  <= S_IDLE;
          cnt    <= '0;
        end
        S_IDLE: begin
          if (bus.start || ((PERIOD != 0) && (cnt == PERIOD))) begin
            state <= S_ACC;
            cnt   <= '0;
          end else if (PERIOD != 0) begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.baseline    = base_w;
  assign bus.upd         = upd_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: doc/baseline_tracker.md
# baseline_tracker

Multi-channel successor to the single-shot baseline measurement: after a power-up settling wait, each of NCH ADC channels is averaged over a power-of-two window of accepted samples, and the result is published as a per-channel baseline. Unlike the single-shot block, it re-measures periodically or on request, rejects pulse-like samples once a baseline exists, and flags channels that time out. It sits between the ADC capture stage and the trigger/pedestal-subtraction logic.

## Interface
- NCH, 2, number of ADC channels
- DW, 14, sample and baseline width (unsigned)
- LOG2N, 7, window = 2^LOG2N accepted samples per channel
- INITWAIT, 1000000, settling cycles after reset release before the first window
- PERIOD, 0, idle cycles between automatic re-measurements; 0 = no automatic re-measurement
- THRESH, 0, rejection half-width in LSB; 0 = accept every sample
- MAXCYC, 65535, maximum cycles allowed in one window before timeout

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- indata  in  NCH*DW  channel c at bits [c*DW +: DW]
- in_valid  in  1  all channels carry a new sample this cycle
- start  in  1  single-cycle re-measure request
- baseline  out  NCH*DW  registered per-channel baseline, same packing as indata
- done  out  1  high once every channel has completed at least one window successfully
- upd  out  1  one-cycle pulse when a window closes
- timeout_err  out  NCH  per-channel timeout flag

One clock; reset is asynchronous and active-low.

## Operation
- States: WAIT -> ACC -> CLOSE -> IDLE -> ACC ...
- WAIT: cycle counter runs from reset release; after INITWAIT cycles, enter ACC. in_valid is ignored.
- ACC: on every in_valid cycle, each channel that is not yet full tests its sample. A sample is accepted if THRESH==0, or the channel has no valid baseline yet, or |sample - baseline| <= THRESH. Accepted samples are added to a (DW+LOG2N)-bit accumulator and increment the channel's count. A channel is full when count == 2^LOG2N, and it ignores further samples.
- Leave ACC for CLOSE when all channels are full, or when the ACC cycle counter reaches MAXCYC.
- CLOSE (one cycle): for each full channel, baseline <= acc >> LOG2N (floor), that channel's valid flag is set, and its timeout_err is cleared. A non-full channel keeps its old baseline, and its timeout_err is set. upd pulses. Accumulators, counts and the cycle counter are cleared. done is set when every channel's valid flag is set, and it never falls except on reset.
- IDLE: if start, enter ACC next cycle; else if PERIOD>0 and the idle counter reaches PERIOD, enter ACC; else stay.
- start in WAIT, ACC or CLOSE is ignored and not queued.
- Same cycle in ACC where the last channel becomes full and MAXCYC is reached: completion wins, and no timeout_err is set.
- Accumulator cannot overflow: 2^LOG2N samples * (2^DW - 1) fits in DW+LOG2N bits.
- Reset mid-operation: all state is cleared. That includes baseline and the valid flags, so rejection is disabled again for the first window.

## Timing
- Reset values: baseline=0, done=0, upd=0, timeout_err=0, state=WAIT.
- First ACC cycle = INITWAIT cycles after the first clk edge with rst_n high.
- Sample accepted on edge k becomes visible in the accumulator at edge k+1.
- baseline, upd, done and timeout_err all change on the edge that leaves CLOSE. This is one cycle after the edge at which the last channel became full, or at which the timeout was reached.
- upd is high for exactly one cycle per window.
- PERIOD counts IDLE cycles. With PERIOD=P, the next ACC begins P+1 cycles after upd.

## Structure
- Package baseline_pkg: state enum (WAIT, ACC, CLOSE, IDLE) and an accumulator-width constant function (DW+LOG2N).
- Sub-module baseline_chan, instantiated NCH times. Each instance holds one channel's accumulator, count, rejection compare, valid flag and baseline register. It takes clear/close strobes and in_valid, and reports its full flag.
- The top holds the FSM, the WAIT/ACC/IDLE counters, and the done/upd/timeout_err aggregation.

## Test plan
- Settling wait: INITWAIT=10, LOG2N=2, constant 100/200 on ch0/ch1, in_valid=1 -> upd at cycle 10+4+1, baseline = 100/200, done=1.
- Floor averaging: LOG2N=2, ch0 samples 1,2,2,2 -> baseline 1. Check ch1 at full-scale 16383 x4 -> baseline 16383, no overflow.
- Rejection: THRESH=5, baseline 100, start pulse, feed 100,300,101,99,100 -> 300 rejected, baseline 100, upd after the fifth valid sample.
- Timeout: MAXCYC=20, ch1 always outside THRESH -> upd after 20 ACC cycles, timeout_err=2'b10, ch1 baseline unchanged, ch0 updated.
- Periodic/start: PERIOD=8 -> ACC re-entered 9 cycles after each upd. A start during ACC has no effect; a start in IDLE gives ACC on the next cycle.
- Reset mid-ACC: assert rst_n low for one cycle -> all outputs 0, WAIT restarts, first window accepts all samples.
